// File: rtl/vscale_hasti_multi_arbiter_pkg.sv
// Shared vscale HASTI widths and encodings used by the multi-master arbiter and its bus interface.
package vscale_hasti_multi_arbiter_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [HASTI_RESP_WIDTH-1:0]  HRESP_OKAY    = 1'b0;

  localparam int STAT_WIDTH = 16;

  function automatic logic hasti_is_req(input logic [HASTI_TRANS_WIDTH-1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/vscale_hasti_multi_arbiter_if.sv
// Bus bundle of the arbiter: flattened per-master HASTI ports plus the single slave port.
interface vscale_hasti_multi_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  import vscale_hasti_multi_arbiter_pkg::*;

  logic [NUM_MASTERS-1:0][HASTI_ADDR_WIDTH-1:0]  m_haddr;
  logic [NUM_MASTERS-1:0]                        m_hwrite;
  logic [NUM_MASTERS-1:0][HASTI_SIZE_WIDTH-1:0]  m_hsize;
  logic [NUM_MASTERS-1:0][HASTI_BURST_WIDTH-1:0] m_hburst;
  logic [NUM_MASTERS-1:0]                        m_hmastlock;
  logic [NUM_MASTERS-1:0][HASTI_PROT_WIDTH-1:0]  m_hprot;
  logic [NUM_MASTERS-1:0][HASTI_TRANS_WIDTH-1:0] m_htrans;
  logic [NUM_MASTERS-1:0][HASTI_BUS_WIDTH-1:0]   m_hwdata;
  logic [NUM_MASTERS-1:0][HASTI_BUS_WIDTH-1:0]   m_hrdata;
  logic [NUM_MASTERS-1:0]                        m_hready;
  logic [NUM_MASTERS-1:0][HASTI_RESP_WIDTH-1:0]  m_hresp;

  logic [HASTI_ADDR_WIDTH-1:0]  s_haddr;
  logic                         s_hwrite;
  logic [HASTI_SIZE_WIDTH-1:0]  s_hsize;
  logic [HASTI_BURST_WIDTH-1:0] s_hburst;
  logic                         s_hmastlock;
  logic [HASTI_PROT_WIDTH-1:0]  s_hprot;
  logic [HASTI_TRANS_WIDTH-1:0] s_htrans;
  logic [HASTI_BUS_WIDTH-1:0]   s_hwdata;
  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata;
  logic                         s_hready;
  logic [HASTI_RESP_WIDTH-1:0]  s_hresp;

  // Arbiter view: accepts master requests, drives the slave.
  modport slave (
    input  m_haddr, m_hwrite, m_hsize, m_hburst, m_hmastlock, m_hprot, m_htrans, m_hwdata,
    output m_hrdata, m_hready, m_hresp,
    output s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata,
    input  s_hrdata, s_hready, s_hresp
  );

  // Environment view: the masters and the slave around the arbiter.
  modport master (
    output m_haddr, m_hwrite, m_hsize, m_hburst, m_hmastlock, m_hprot, m_htrans, m_hwdata,
    input  m_hrdata, m_hready, m_hresp,
    input  s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata,
    output s_hrdata, s_hready, s_hresp
  );

endinterface

// File: rtl/vscale_hasti_multi_arbiter_rr_picker.sv
// Round-robin scan: first requester strictly after i_last, wrapping; i_last itself is the lowest priority.
module vscale_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_WIDTH-1:0]   i_last,
  output logic [IDX_WIDTH-1:0]   o_pick,
  output logic                   o_pick_vld
);

  always_comb begin
    int idx;
    idx        = 0;
    o_pick     = i_last;
    o_pick_vld = 1'b0;
    // Walk from farthest to nearest so the nearest requester after i_last is left standing.
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = int'(i_last) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (i_req[idx]) begin
        o_pick     = IDX_WIDTH'(idx);
        o_pick_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vscale_hasti_multi_arbiter.sv
// Multi-master HASTI arbiter: zero-latency address mux from registered address/data-phase owners; non-owners stall on m_hready=0.
// Optional per-master saturating grant counters when VSCALE_ARB_STATS_EN is defined.
module vscale_hasti_multi_arbiter
  import vscale_hasti_multi_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  vscale_hasti_multi_arbiter_if.slave bus,
  input  logic                   sel_mode,
  input  logic [IDX_WIDTH-1:0]   next_master,
  output logic [IDX_WIDTH-1:0]   grant_idx
`ifdef VSCALE_ARB_STATS_EN
  ,
  output logic [NUM_MASTERS-1:0][STAT_WIDTH-1:0] grant_count
`endif
);

  logic [IDX_WIDTH-1:0]   r_aowner;
  logic [IDX_WIDTH-1:0]   r_downer;
  logic                   r_dvalid;
  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_run;
  logic                   w_a_req;
  logic                   w_a_lock;
  logic                   w_next_ok;
  logic [IDX_WIDTH-1:0]   w_pick;
  logic                   w_pick_vld;
  logic [IDX_WIDTH-1:0]   w_aowner_nxt;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_req
    assign w_req[g] = hasti_is_req(bus.m_htrans[g]);
  end

  // Outputs are blanked for the whole reset cycle, not only after the reset edge.
  assign w_run     = !reset;
  assign w_a_req   = w_req[r_aowner];
  assign w_a_lock  = w_a_req && bus.m_hmastlock[r_aowner];
  assign grant_idx = r_aowner;

  if (NUM_MASTERS < (1 << IDX_WIDTH)) begin : g_idx_chk
    assign w_next_ok = (next_master < IDX_WIDTH'(NUM_MASTERS));
  end else begin : g_idx_full
    assign w_next_ok = 1'b1;
  end

  vscale_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_picker (
    .i_req      (w_req),
    .i_last     (r_aowner),
    .o_pick     (w_pick),
    .o_pick_vld (w_pick_vld)
  );

  always_comb begin
    w_aowner_nxt = r_aowner;
    if (!w_a_lock) begin
      if (sel_mode) begin
        if (w_next_ok) w_aowner_nxt = next_master;
      end else if (w_pick_vld) begin
        w_aowner_nxt = w_pick;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aowner <= '0;
      r_downer <= '0;
      r_dvalid <= 1'b0;
    end else if (bus.s_hready) begin
      r_downer <= r_aowner;
      r_dvalid <= w_a_req;
      r_aowner <= w_aowner_nxt;
    end
  end

  always_comb begin
    bus.s_haddr     = '0;
    bus.s_hwrite    = 1'b0;
    bus.s_hsize     = '0;
    bus.s_hburst    = '0;
    bus.s_hmastlock = 1'b0;
    bus.s_hprot     = '0;
    bus.s_htrans    = HTRANS_IDLE;
    bus.s_hwdata    = '0;
    if (w_run) begin
      bus.s_haddr     = bus.m_haddr[r_aowner];
      bus.s_hwrite    = bus.m_hwrite[r_aowner];
      bus.s_hsize     = bus.m_hsize[r_aowner];
      bus.s_hburst    = bus.m_hburst[r_aowner];
      bus.s_hmastlock = bus.m_hmastlock[r_aowner];
      bus.s_hprot     = bus.m_hprot[r_aowner];
      bus.s_htrans    = w_a_req ? bus.m_htrans[r_aowner] : HTRANS_IDLE;
      if (r_dvalid) bus.s_hwdata = bus.m_hwdata[r_downer];
    end
  end

  always_comb begin
    bus.m_hrdata = '0;
    bus.m_hresp  = {NUM_MASTERS{HRESP_OKAY}};
    bus.m_hready = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_run && r_dvalid && (IDX_WIDTH'(i) == r_downer)) begin
        bus.m_hrdata[i] = bus.s_hrdata;
        bus.m_hresp[i]  = bus.s_hresp;
        bus.m_hready[i] = bus.s_hready;
      end
      if (w_run && (IDX_WIDTH'(i) == r_aowner)) bus.m_hready[i] = bus.s_hready;
    end
  end

`ifdef VSCALE_ARB_STATS_EN
  logic [NUM_MASTERS-1:0][STAT_WIDTH-1:0] r_grant_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_count <= '0;
    end else if (bus.s_hready && w_a_req && (r_grant_count[r_aowner] != '1)) begin
      r_grant_count[r_aowner] <= r_grant_count[r_aowner] + STAT_WIDTH'(1);
    end
  end

  assign grant_count = r_grant_count;
`endif

endmodule

// File: tb/tb_vscale_hasti_multi_arbiter.sv
// Bench for vscale_hasti_multi_arbiter: vector table, corner-case sequences and random traffic against a transfer-level model.
module tb_vscale_hasti_multi_arbiter;
  import vscale_hasti_multi_arbiter_pkg::*;

  localparam int N       = 4;
  localparam int IW      = 2;
  localparam int CNT_MAX = (1 << STAT_WIDTH) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel_mode;
  logic [IW-1:0] next_master;
  logic [IW-1:0] grant_idx;
`ifdef VSCALE_ARB_STATS_EN
  logic [N-1:0][STAT_WIDTH-1:0] grant_count;
`endif

  vscale_hasti_multi_arbiter_if #(.NUM_MASTERS(N)) bus ();

  vscale_hasti_multi_arbiter #(.NUM_MASTERS(N), .IDX_WIDTH(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .sel_mode    (sel_mode),
    .next_master (next_master),
    .grant_idx   (grant_idx)
`ifdef VSCALE_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transfer-level model: who owns the address phase, who owns the data phase.
  int md_a = 0;
  int md_d = 0;
  bit md_dv = 1'b0;
  int md_cnt[N];
  bit model_ok = 1'b0;

  typedef struct {
    logic [N-1:0]  req;
    logic          sel;
    logic [IW-1:0] nxt;
    logic          rdy;
    logic [IW-1:0] exp_grant;
    logic [1:0]    exp_trans;
    logic [N-1:0]  exp_mrdy;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_req(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

  task automatic check_model();
    bit run;
    bit areq;
    logic [N-1:0] exp_rdy;
    if (!model_ok) return;
    run  = !reset;
    areq = is_req(bus.m_htrans[md_a]);
    check("grant_idx", grant_idx, md_a);
    check("s_htrans", bus.s_htrans, (run && areq) ? bus.m_htrans[md_a] : HTRANS_IDLE);
    check("s_haddr", bus.s_haddr, run ? bus.m_haddr[md_a] : 32'h0);
    check("s_hwrite", bus.s_hwrite, run ? bus.m_hwrite[md_a] : 1'b0);
    check("s_hsize", bus.s_hsize, run ? bus.m_hsize[md_a] : 3'h0);
    check("s_hburst", bus.s_hburst, run ? bus.m_hburst[md_a] : 3'h0);
    check("s_hprot", bus.s_hprot, run ? bus.m_hprot[md_a] : 4'h0);
    check("s_hmastlock", bus.s_hmastlock, run ? bus.m_hmastlock[md_a] : 1'b0);
    check("s_hwdata", bus.s_hwdata, (run && md_dv) ? bus.m_hwdata[md_d] : 32'h0);
    for (int i = 0; i < N; i++) begin
      exp_rdy[i] = (run && (i == md_a || (md_dv && i == md_d))) ? bus.s_hready : 1'b0;
      check($sformatf("m_hrdata[%0d]", i), bus.m_hrdata[i],
            (run && md_dv && i == md_d) ? bus.s_hrdata : 32'h0);
      check($sformatf("m_hresp[%0d]", i), bus.m_hresp[i],
            (run && md_dv && i == md_d) ? bus.s_hresp : HRESP_OKAY);
`ifdef VSCALE_ARB_STATS_EN
      check($sformatf("grant_count[%0d]", i), grant_count[i], md_cnt[i]);
`endif
    end
    check("m_hready", bus.m_hready, exp_rdy);
  endtask

  task automatic model_clock();
    bit areq;
    int nxt;
    if (reset) begin
      md_a = 0; md_d = 0; md_dv = 1'b0;
      for (int i = 0; i < N; i++) md_cnt[i] = 0;
    end else if (bus.s_hready) begin
      areq = is_req(bus.m_htrans[md_a]);
      if (areq && md_cnt[md_a] < CNT_MAX) md_cnt[md_a]++;
      nxt = md_a;
      if (!(areq && bus.m_hmastlock[md_a])) begin
        if (sel_mode) begin
          if (int'(next_master) < N) nxt = int'(next_master);
        end else begin
          for (int off = N; off >= 1; off--)
            if (is_req(bus.m_htrans[(md_a + off) % N])) nxt = (md_a + off) % N;
        end
      end
      md_d  = md_a;
      md_dv = areq;
      md_a  = nxt;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.m_haddr = '0; bus.m_hwrite = '0; bus.m_hsize = '0; bus.m_hburst = '0;
    bus.m_hmastlock = '0; bus.m_hprot = '0; bus.m_htrans = '0; bus.m_hwdata = '0;
    bus.s_hrdata = '0; bus.s_hready = 1'b1; bus.s_hresp = HRESP_OKAY;
    sel_mode = 1'b0; next_master = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    settle();
    advance();
    model_ok = 1'b1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    // Reset state with every master requesting and the slave ready.
    for (int i = 0; i < N; i++) bus.m_htrans[i] = HTRANS_NONSEQ;
    advance();
    model_ok = 1'b1;
    settle();
    check("reset grant_idx", grant_idx, 0);
    check("reset s_htrans", bus.s_htrans, HTRANS_IDLE);
    check("reset s_haddr", bus.s_haddr, 0);
    check("reset s_hwdata", bus.s_hwdata, 0);
    check("reset m_hready", bus.m_hready, 0);
    advance();
    reset = 1'b0;

    // Table: round robin, idle hold, external select, stall, idle-owner handover.
    vecs[0]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd0, HTRANS_NONSEQ, 4'b0001};
    vecs[1]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd1, HTRANS_NONSEQ, 4'b0011};
    vecs[2]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd2, HTRANS_NONSEQ, 4'b0110};
    vecs[3]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd3, HTRANS_NONSEQ, 4'b1100};
    vecs[4]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd0, HTRANS_NONSEQ, 4'b1001};
    vecs[5]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 2'd1, HTRANS_NONSEQ, 4'b0011};
    vecs[6]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 2'd2, HTRANS_IDLE,   4'b0110};
    vecs[7]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 2'd2, HTRANS_IDLE,   4'b0100};
    vecs[8]  = '{4'b1001, 1'b1, 2'd3, 1'b1, 2'd2, HTRANS_IDLE,   4'b0100};
    vecs[9]  = '{4'b1001, 1'b1, 2'd3, 1'b1, 2'd3, HTRANS_NONSEQ, 4'b1000};
    vecs[10] = '{4'b1001, 1'b1, 2'd3, 1'b1, 2'd3, HTRANS_NONSEQ, 4'b1000};
    vecs[11] = '{4'b1001, 1'b1, 2'd0, 1'b1, 2'd3, HTRANS_NONSEQ, 4'b1000};
    vecs[12] = '{4'b1001, 1'b1, 2'd0, 1'b1, 2'd0, HTRANS_NONSEQ, 4'b1001};
    vecs[13] = '{4'b0100, 1'b0, 2'd0, 1'b0, 2'd0, HTRANS_IDLE,   4'b0000};
    vecs[14] = '{4'b0100, 1'b0, 2'd0, 1'b1, 2'd0, HTRANS_IDLE,   4'b0001};
    vecs[15] = '{4'b0100, 1'b0, 2'd0, 1'b1, 2'd2, HTRANS_NONSEQ, 4'b0100};
    set_idle();
    do_reset();
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < N; i++) begin
        bus.m_htrans[i] = vecs[v].req[i] ? HTRANS_NONSEQ : HTRANS_IDLE;
        bus.m_haddr[i]  = 32'h1000 * (i + 1);
      end
      sel_mode    = vecs[v].sel;
      next_master = vecs[v].nxt;
      bus.s_hready = vecs[v].rdy;
      settle();
      check($sformatf("vec%0d grant_idx", v), grant_idx, vecs[v].exp_grant);
      check($sformatf("vec%0d s_htrans", v), bus.s_htrans, vecs[v].exp_trans);
      check($sformatf("vec%0d m_hready", v), bus.m_hready, vecs[v].exp_mrdy);
      advance();
    end

    // Single requester streams back-to-back after one handover cycle.
    set_idle();
    do_reset();
    bus.m_htrans[2] = HTRANS_NONSEQ;
    bus.m_haddr[2]  = 32'h2000;
    settle();
    check("solo handover s_htrans", bus.s_htrans, HTRANS_IDLE);
    advance();
    for (int k = 0; k < 5; k++) begin
      bus.m_haddr[2] = 32'h2000 + 32'(4 * k);
      settle();
      check($sformatf("solo%0d s_htrans", k), bus.s_htrans, HTRANS_NONSEQ);
      check($sformatf("solo%0d m_hready[2]", k), bus.m_hready[2], 1'b1);
      check($sformatf("solo%0d s_haddr", k), bus.s_haddr, 32'h2000 + 32'(4 * k));
      advance();
    end

    // Write data phase stalled by the slave for three cycles.
    set_idle();
    do_reset();
    bus.m_htrans[1] = HTRANS_NONSEQ;
    bus.m_hwrite[1] = 1'b1;
    bus.m_haddr[1]  = 32'h40;
    settle();
    advance();
    settle();
    check("wr addr grant_idx", grant_idx, 1);
    check("wr addr s_hwrite", bus.s_hwrite, 1'b1);
    advance();
    bus.m_htrans[1] = HTRANS_IDLE;
    bus.m_hwdata[1] = 32'hDEADBEEF;
    bus.m_htrans[3] = HTRANS_NONSEQ;
    bus.s_hready    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("stall%0d s_hwdata", k), bus.s_hwdata, 32'hDEADBEEF);
      check($sformatf("stall%0d grant_idx", k), grant_idx, 1);
      check($sformatf("stall%0d m_hready", k), bus.m_hready, 4'b0000);
      advance();
    end
    bus.s_hready = 1'b1;
    settle();
    check("stall release s_hwdata", bus.s_hwdata, 32'hDEADBEEF);
    check("stall release m_hready[1]", bus.m_hready[1], 1'b1);
    advance();
    settle();
    check("after write s_hwdata", bus.s_hwdata, 32'h0);
    check("after write grant_idx", grant_idx, 3);
    advance();

    // Locked master 0 keeps the bus against master 1 in either select mode.
    set_idle();
    do_reset();
    bus.m_htrans[0]    = HTRANS_NONSEQ;
    bus.m_hmastlock[0] = 1'b1;
    bus.m_htrans[1]    = HTRANS_NONSEQ;
    for (int k = 0; k < 3; k++) begin
      sel_mode    = (k == 2);
      next_master = 2'd1;
      settle();
      check($sformatf("lock%0d grant_idx", k), grant_idx, 0);
      check($sformatf("lock%0d m_hready[1]", k), bus.m_hready[1], 1'b0);
      advance();
    end
    sel_mode = 1'b0;
    bus.m_hmastlock[0] = 1'b0;
    settle();
    check("unlock grant_idx", grant_idx, 0);
    advance();
    settle();
    check("after unlock grant_idx", grant_idx, 1);
    check("after unlock m_hready[1]", bus.m_hready[1], 1'b1);
    advance();

    // Reset during a data phase drops the response path.
    set_idle();
    do_reset();
    bus.m_htrans[3] = HTRANS_NONSEQ;
    settle();
    advance();
    settle();
    advance();
    bus.s_hrdata = 32'hCAFE0001;
    settle();
    check("data phase m_hrdata[3]", bus.m_hrdata[3], 32'hCAFE0001);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    settle();
    check("post-reset s_htrans", bus.s_htrans, HTRANS_IDLE);
    check("post-reset m_hrdata[3]", bus.m_hrdata[3], 32'h0);
    check("post-reset m_hready[3]", bus.m_hready[3], 1'b0);
    check("post-reset grant_idx", grant_idx, 0);
`ifdef VSCALE_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check($sformatf("post-reset grant_count[%0d]", i), grant_count[i], 0);
`endif
    advance();

    // Random traffic against the model.
    set_idle();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.m_htrans[i]    = 2'($urandom_range(0, 3));
        bus.m_haddr[i]     = $urandom();
        bus.m_hwrite[i]    = 1'($urandom_range(0, 1));
        bus.m_hsize[i]     = 3'($urandom_range(0, 7));
        bus.m_hburst[i]    = 3'($urandom_range(0, 7));
        bus.m_hprot[i]     = 4'($urandom_range(0, 15));
        bus.m_hwdata[i]    = $urandom();
        bus.m_hmastlock[i] = ($urandom_range(0, 5) == 0);
      end
      bus.s_hready = ($urandom_range(0, 3) != 0);
      bus.s_hrdata = $urandom();
      bus.s_hresp  = 1'($urandom_range(0, 1));
      sel_mode     = ($urandom_range(0, 3) == 0);
      next_master  = 2'($urandom_range(0, 3));
      reset        = ($urandom_range(0, 49) == 0);
      settle();
      advance();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
